// File: rtl/out_arbiter.sv
// out_arbiter: round-robin arbiter time-sharing the output pins between up to
// N_REQ submodule datapaths. Grants last at least MIN_HOLD cycles; a waiting
// requester preempts after MAX_HOLD. One blank GAP cycle separates grants.
// A force mode pins the bus to one requester for debug.
// The per-requester release strobe is named 'rel' because 'release' is a
// reserved word in SystemVerilog.
module out_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int DATA_W   = 8,
  parameter  int MIN_HOLD = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = $clog2(N_REQ),
  localparam int HOLD_W   = $clog2(MAX_HOLD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rel,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    force_en,
  input  logic [IDX_W-1:0]        force_sel,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    busy,
  output logic [7:0]              switch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  gidx, gidx_nx;
  logic [IDX_W-1:0]  rr_ptr, rr_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic              rel_pend, rel_pend_nx;
  // Set when the current grant was entered through force mode; lets a rising
  // force_en be told apart from a grant that force mode is already holding.
  logic              forced, forced_nx;
  logic [7:0]        switch_cnt_nx;

  logic [N_REQ-1:0]  gidx_oh;
  logic              scan_hit;
  logic [IDX_W-1:0]  scan_idx;
  logic              done, others_wait, min_ok, max_ok;

  assign gidx_oh     = N_REQ'(1) << gidx;
  assign done        = rel_pend | rel[gidx] | ~req[gidx];
  assign others_wait = |(req & ~gidx_oh);
  assign min_ok      = hold_cnt >= HOLD_W'(MIN_HOLD - 1);
  assign max_ok      = hold_cnt >= HOLD_W'(MAX_HOLD - 1);

  // Round-robin scan: first requester at or after rr_ptr. N_REQ is a power of
  // two, so the IDX_W-bit sum wraps modulo N_REQ on its own. Scanning from the
  // far end lets the nearest hit overwrite earlier ones.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = rr_ptr;
    for (int s = N_REQ - 1; s >= 0; s--) begin
      if (req[rr_ptr + IDX_W'(s)]) begin
        scan_hit = 1'b1;
        scan_idx = rr_ptr + IDX_W'(s);
      end
    end
  end

  // Next-state and register-update logic for the IDLE/GRANT/GAP sequencer.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path can infer a latch.
    state_nx      = state;
    gidx_nx       = gidx;
    rr_nx         = rr_ptr;
    hold_nx       = hold_cnt;
    rel_pend_nx   = rel_pend;
    forced_nx     = forced;
    switch_cnt_nx = switch_cnt;

    unique case (state)
      S_IDLE: begin
        if (force_en || scan_hit) begin
          state_nx    = S_GRANT;
          gidx_nx     = force_en ? force_sel : scan_idx;
          forced_nx   = force_en;
          hold_nx     = '0;
          rel_pend_nx = 1'b0;
          if (switch_cnt != 8'hFF) switch_cnt_nx = switch_cnt + 8'd1;
        end
      end

      S_GRANT: begin
        if (forced) begin
          // Debug hold: only dropping force or retargeting it ends the grant.
          if (!force_en || (force_sel != gidx)) state_nx = S_GAP;
        end else if (force_en) begin
          // Force raised over an auto grant: leave at once, ignoring MIN_HOLD.
          state_nx = S_GAP;
          rr_nx    = gidx + IDX_W'(1);
        end else begin
          if (hold_cnt != '1) hold_nx = hold_cnt + HOLD_W'(1);
          if (rel[gidx]) rel_pend_nx = 1'b1;
          if ((min_ok && done) || (max_ok && others_wait)) begin
            state_nx = S_GAP;
            rr_nx    = gidx + IDX_W'(1);
          end
        end
      end

      S_GAP: state_nx = S_IDLE;

      default: state_nx = S_IDLE;
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gidx       <= '0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      rel_pend   <= 1'b0;
      forced     <= 1'b0;
      switch_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      gidx       <= gidx_nx;
      rr_ptr     <= rr_nx;
      hold_cnt   <= hold_nx;
      rel_pend   <= rel_pend_nx;
      forced     <= forced_nx;
      switch_cnt <= switch_cnt_nx;
    end
  end

  // Outputs decode the registered state, so reset clears them without a clock.
  always_comb begin
    grant   = (state == S_GRANT) ? gidx_oh : '0;
    bus_out = (state == S_GRANT) ? data_in[gidx*DATA_W +: DATA_W] : '0;
    busy    = (state != S_IDLE);
  end

endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: scoreboard bench. The driver steps a transaction-level
// reference model (grant owner, grant length, gap, idle) once per cycle and
// queues the expected outputs; a monitor pops and compares after every edge
// and also logs each observed grant episode (owner, length).
module tb_out_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MIN = 4;
  localparam int MAX = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, rel;
  logic [N*W-1:0] data_in;
  logic         force_en;
  logic [1:0]   force_sel;
  logic [N-1:0] grant;
  logic [W-1:0] bus_out;
  logic         busy;
  logic [7:0]   switch_cnt;

  out_arbiter #(.N_REQ(N), .DATA_W(W), .MIN_HOLD(MIN), .MAX_HOLD(MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .data_in(data_in),
    .force_en(force_en), .force_sel(force_sel), .grant(grant),
    .bus_out(bus_out), .busy(busy), .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] bus;
    logic         busy;
    logic [7:0]   cnt;
  } exp_t;

  typedef struct {
    int owner;
    int len;
  } ep_t;

  exp_t sb[$];
  ep_t  ep_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 granted, 2 gap. len counts grant cycles including the current one.
  int   m_phase, m_owner, m_len, m_rr, m_cnt;
  bit   m_forced, m_relp;
  logic [N*W-1:0] data_v;

  function automatic void m_reset();
    m_phase = 0; m_owner = 0; m_len = 0; m_rr = 0; m_cnt = 0;
    m_forced = 0; m_relp = 0;
  endfunction

  function automatic void m_enter(int k, bit f);
    m_phase = 1; m_owner = k; m_len = 1; m_forced = f; m_relp = 0;
    if (m_cnt < 255) m_cnt++;
  endfunction

  function automatic void m_edge(logic [N-1:0] r, logic [N-1:0] rl, logic fe, logic [1:0] fs);
    bit leave, found, dn, oth;
    leave = 0;
    found = 0;
    case (m_phase)
      0: begin
        if (fe) m_enter(int'(fs), 1);
        else begin
          for (int s = 0; s < N; s++) begin
            if (!found && r[(m_rr + s) % N]) begin
              found = 1;
              m_enter((m_rr + s) % N, 0);
            end
          end
        end
      end
      1: begin
        if (m_forced) leave = !fe || (int'(fs) != m_owner);
        else if (fe) begin
          leave = 1;
          m_rr = (m_owner + 1) % N;
        end else begin
          dn  = m_relp || rl[m_owner] || !r[m_owner];
          oth = (r & ~(N'(1) << m_owner)) != '0;
          if ((m_len >= MIN && dn) || (m_len >= MAX && oth)) begin
            leave = 1;
            m_rr = (m_owner + 1) % N;
          end
          if (rl[m_owner]) m_relp = 1;
        end
        if (leave) m_phase = 2;
        else m_len++;
      end
      default: m_phase = 0;
    endcase
  endfunction

  // One stimulus cycle: drive at the falling edge, step the model, queue the expectation.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] rl,
                       input logic fe, input logic [1:0] fs);
    exp_t e;
    @(negedge clk);
    req = r; rel = rl; force_en = fe; force_sel = fs; data_in = data_v;
    m_edge(r, rl, fe, fs);
    e.grant = (m_phase == 1) ? N'(1) << m_owner : '0;
    e.bus   = (m_phase == 1) ? data_v[m_owner*W +: W] : '0;
    e.busy  = (m_phase != 0);
    e.cnt   = 8'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 2'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    logic [N-1:0] prev;
    int cur_owner, cur_len;
    ep_t ep;
    prev = '0; cur_owner = 0; cur_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("bus_out", 32'(bus_out), 32'(e.bus));
        check("busy", 32'(busy), 32'(e.busy));
        check("switch_cnt", 32'(switch_cnt), 32'(e.cnt));
      end
      if (prev != '0 && grant != prev) begin
        ep.owner = cur_owner; ep.len = cur_len;
        ep_q.push_back(ep);
      end
      if (grant != '0 && grant != prev) begin
        cur_len = 1;
        for (int i = 0; i < N; i++) if (grant[i]) cur_owner = i;
      end else if (grant != '0) cur_len++;
      prev = grant;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; rel = '0; force_en = 1'b0; force_sel = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [N-1:0] rr_req, rr_rel;
    logic         rfe;
    logic [1:0]   rfs;
    rst = 1'b1; req = '0; rel = '0; force_en = 1'b0; force_sel = '0;
    data_v = '0; data_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset and idle: nothing happens for 20 cycles.
    idle(20);
    @(posedge clk); #2;
    check("idle_switch_cnt", 32'(switch_cnt), 32'd0);

    // Single requester with an early release: exactly MIN_HOLD cycles.
    ep_q.delete();
    data_v = {$urandom()};
    data_v[7:0] = 8'hA5;
    cycle(4'b0001, '0, 0, 0);
    cycle(4'b0001, '0, 0, 0);
    cycle(4'b0001, 4'b0001, 0, 0);
    cycle(4'b0001, '0, 0, 0);
    cycle(4'b0001, '0, 0, 0);
    idle(4);
    @(posedge clk); #2;
    check("single_ep_count", 32'(ep_q.size()), 32'd1);
    if (ep_q.size() >= 1) begin
      check("single_owner", 32'(ep_q[0].owner), 32'd0);
      check("single_len", 32'(ep_q[0].len), 32'(MIN));
    end

    // Asynchronous reset in the middle of a grant.
    data_v = {$urandom()} | 32'h0000_FF00;
    cycle(4'b0010, '0, 0, 0);
    cycle(4'b0010, '0, 0, 0);
    @(posedge clk); #3;
    check("pre_reset_grant", 32'(grant), 32'b0010);
    rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_bus", 32'(bus_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    hard_reset();

    // Round robin with all four requesting: 0,1,2,3,0, each MAX_HOLD long.
    ep_q.delete();
    for (int i = 0; i < 89; i++) begin
      data_v = {$urandom()};
      cycle(4'b1111, '0, 0, 0);
    end
    idle(5);
    @(posedge clk); #2;
    check("rr_ep_count", 32'(ep_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < ep_q.size(); i++) begin
      check("rr_owner", 32'(ep_q[i].owner), 32'(i % N));
      check("rr_len", 32'(ep_q[i].len), 32'(MAX));
    end
    check("rr_switch_cnt", 32'(switch_cnt), 32'd5);

    // Persistent holder: no preemption until a second requester appears.
    ep_q.delete();
    for (int i = 1; i <= 100; i++) begin
      data_v = {$urandom()};
      cycle((i < 50) ? 4'b0100 : 4'b0110, '0, 0, 0);
    end
    idle(30);
    @(posedge clk); #2;
    if (ep_q.size() >= 2) begin
      check("persist_owner", 32'(ep_q[0].owner), 32'd2);
      check("persist_len", 32'(ep_q[0].len), 32'd49);
      check("handover_owner", 32'(ep_q[1].owner), 32'd1);
    end else check("persist_ep_count", 32'(ep_q.size()), 32'd2);

    // Force mode: preempt an auto grant, retarget, then drop force.
    ep_q.delete();
    data_v = {$urandom()};
    cycle(4'b0100, '0, 0, 2'd0);
    cycle(4'b0100, '0, 0, 2'd0);
    for (int i = 0; i < 12; i++) cycle(4'b0100, '0, 1, 2'd3);
    for (int i = 0; i < 10; i++) cycle(4'b0100, '0, 1, 2'd0);
    idle(4);
    @(posedge clk); #2;
    check("force_ep_count", 32'(ep_q.size()), 32'd3);
    if (ep_q.size() >= 3) begin
      check("force_preempted_owner", 32'(ep_q[0].owner), 32'd2);
      check("force_preempted_len", 32'(ep_q[0].len), 32'd2);
      check("force_owner_a", 32'(ep_q[1].owner), 32'd3);
      check("force_owner_b", 32'(ep_q[2].owner), 32'd0);
    end
    check("force_end_busy", 32'(busy), 32'd0);

    // Randomised traffic with occasional releases and force episodes.
    rr_req = '0; rfe = 1'b0; rfs = '0;
    for (int i = 0; i < 3000; i++) begin
      data_v = {$urandom()};
      if ($urandom_range(0, 7) == 0) rr_req = N'($urandom());
      rr_rel = ($urandom_range(0, 5) == 0) ? N'($urandom()) : '0;
      if ($urandom_range(0, 63) == 0) rfe = ~rfe;
      if ($urandom_range(0, 15) == 0) rfs = 2'($urandom());
      cycle(rr_req, rr_rel, rfe, rfs);
    end
    idle(20);

    // Saturation: 300 short grants; switch_cnt stops at 255.
    for (int i = 0; i < 1800; i++) begin
      data_v = {$urandom()};
      cycle(4'b0001, 4'b0001, 0, 0);
    end
    idle(5);
    @(posedge clk); #2;
    check("sat_switch_cnt", 32'(switch_cnt), 32'd255);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
